// File: rtl/irq_ctrl_param.sv
// rtl/irq_ctrl_param.sv - parametrised memory-mapped interrupt controller
// Fixed-priority arbitration with a two-phase attended/complete handshake to the CPU.
module irq_ctrl_param #(
  parameter int NUM_SOURCES = 8,
  parameter int NUM_W       = $clog2(NUM_SOURCES)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_WEnable,
  input  logic [31:0]            i_WAddr,
  input  logic [31:0]            i_WData,
  input  logic                   i_REnable,
  input  logic [31:0]            i_RAddr,
  output logic [31:0]            o_RData,
  output logic                   o_Err,
  input  logic [NUM_SOURCES-1:0] i_Sources,
  input  logic                   i_AckAttended,
  input  logic                   i_AckComplete,
  output logic                   o_IrqReq,
  output logic [NUM_W-1:0]       o_IrqNumber
);
  localparam logic [31:0] ADDR_CTRL    = 32'h00;
  localparam logic [31:0] ADDR_ENABLE  = 32'h04;
  localparam logic [31:0] ADDR_MODE    = 32'h08;
  localparam logic [31:0] ADDR_PENDING = 32'h0C;
  localparam logic [31:0] ADDR_STATUS  = 32'h10;
  localparam logic [31:0] ADDR_SWTRIG  = 32'h14;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;
  state_t state, state_next;

  logic                   ea;
  logic [NUM_SOURCES-1:0] enable, mode, pending, pending_next;
  logic [NUM_SOURCES-1:0] sync1, sync2, prev;
  logic [NUM_SOURCES-1:0] sw_set, w1c, ack_clr, edge_set, candidates;
  logic                   wr_err, rd_err, wr_ok, rd_ok;
  logic [31:0]            rdata_mux;
  logic                   any_cand, cur_enabled;
  logic [NUM_W-1:0]       cand_idx, irq_num_next;
  logic                   irq_req_next;
  logic                   unused_wdata;

  assign unused_wdata = &{1'b0, i_WData};

  always_comb begin
    wr_err = (i_WAddr[1:0] != 2'b00) || (i_WAddr > ADDR_SWTRIG) || (i_WAddr == ADDR_STATUS);
    rd_err = (i_RAddr[1:0] != 2'b00) || (i_RAddr > ADDR_SWTRIG) || (i_RAddr == ADDR_SWTRIG);
    wr_ok  = i_WEnable && !wr_err;
    // A simultaneous write wins the bus; the read is dropped entirely.
    rd_ok  = i_REnable && !i_WEnable && !rd_err;
  end

  always_comb begin
    rdata_mux = '0;
    case (i_RAddr)
      ADDR_CTRL:    rdata_mux[0] = ea;
      ADDR_ENABLE:  rdata_mux[NUM_SOURCES-1:0] = enable;
      ADDR_MODE:    rdata_mux[NUM_SOURCES-1:0] = mode;
      ADDR_PENDING: rdata_mux[NUM_SOURCES-1:0] = pending;
      ADDR_STATUS: begin
        rdata_mux[0]          = o_IrqReq;
        rdata_mux[1]          = (state == ST_SERVICE);
        rdata_mux[8 +: NUM_W] = o_IrqNumber;
      end
      default: rdata_mux = '0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      ea      <= 1'b0;
      enable  <= '0;
      mode    <= '0;
      o_RData <= '0;
      o_Err   <= 1'b0;
    end else begin
      if (wr_ok) begin
        case (i_WAddr)
          ADDR_CTRL:   ea     <= i_WData[0];
          ADDR_ENABLE: enable <= i_WData[NUM_SOURCES-1:0];
          ADDR_MODE:   mode   <= i_WData[NUM_SOURCES-1:0];
          default: ;
        endcase
      end
      if (rd_ok) o_RData <= rdata_mux;
      o_Err <= i_WEnable ? wr_err : (i_REnable && rd_err);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      pending <= '0;
    end else begin
      sync1   <= i_Sources;
      sync2   <= sync1;
      prev    <= sync2;
      pending <= pending_next;
    end
  end

  // Edge-mode bits: any set source beats any clear source in the same cycle.
  always_comb begin
    sw_set  = '0;
    w1c     = '0;
    ack_clr = '0;
    if (wr_ok && (i_WAddr == ADDR_SWTRIG))  sw_set = i_WData[NUM_SOURCES-1:0];
    if (wr_ok && (i_WAddr == ADDR_PENDING)) w1c    = i_WData[NUM_SOURCES-1:0];
    if ((state == ST_REQ) && i_AckAttended) ack_clr[o_IrqNumber] = 1'b1;
    edge_set     = (sync2 & ~prev) | sw_set;
    pending_next = (mode & (edge_set | (pending & ~(w1c | ack_clr)))) | (~mode & sync2);
  end

  always_comb begin
    candidates = pending & enable & {NUM_SOURCES{ea}};
    any_cand   = |candidates;
    cand_idx   = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (candidates[i]) cand_idx = NUM_W'(i);
    end
    cur_enabled = ea && enable[o_IrqNumber];
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= ST_IDLE;
      o_IrqReq    <= 1'b0;
      o_IrqNumber <= '0;
    end else begin
      state       <= state_next;
      o_IrqReq    <= irq_req_next;
      o_IrqNumber <= irq_num_next;
    end
  end

  always_comb begin
    state_next   = state;
    irq_req_next = o_IrqReq;
    irq_num_next = o_IrqNumber;
    case (state)
      ST_IDLE: begin
        if (any_cand) begin
          irq_num_next = cand_idx;
          irq_req_next = 1'b1;
          state_next   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_AckAttended) begin
          irq_req_next = 1'b0;
          state_next   = ST_SERVICE;
        end else if (!cur_enabled) begin
          irq_req_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (i_AckComplete) state_next = ST_IDLE;
      end
      default: begin
        irq_req_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase
  end
endmodule
